mine_field_init: RTL and testbench
==================================

# mine_field_init

Board initialisation stage for the minesweeper game. On `start` it places `MINES` mines pseudo-randomly with an LFSR, then streams one cell word per cycle (mine bit plus neighbour count) into the board memory in row-major order. When the last cell has been written it pulses `ultima_casilla`, which starts the game-control FSM downstream.

## Interface
- `ROWS`, default 8: board rows, range 2..16.
- `COLS`, default 8: board columns, range 2..16.
- `MINES`, default 10: mines to place, range 0..ROWS*COLS-1.
- `LFSR_SEED`, default 16'hACE1: LFSR reset value; must be non-zero.
- Derived: N = ROWS*COLS, AW = clog2(N).
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: single-cycle request to build a new board; sampled only in IDLE.
- `wr_en` out 1: board memory write strobe.
- `wr_addr` out AW: cell address, row*COLS+col.
- `wr_data` out 5: [4] mine flag, [3:0] count of adjacent mines (0..8).
- `busy` out 1: high in PLACE and WRITE.
- `ultima_casilla` out 1: one-cycle pulse after the last cell write.

## Operation
- State machine: IDLE, PLACE, WRITE, DONE.
- Internal state: N-bit mine bitmap, mine counter sized for MINES, AW-bit cell index.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Free-runs every cycle in every state, so the seed effectively depends on when `start` arrives.
- IDLE:
  - `start`=1 clears the bitmap and mine counter; next state PLACE.
  - `start`=0 stays in IDLE.
- PLACE, one candidate per cycle:
  - Candidate is `lfsr[AW-1:0]`.
  - Reject if the candidate is >= N or its bitmap bit is already set.
  - Otherwise set the bit and increment the counter.
  - When the counter equals MINES at the start of a cycle, go to WRITE and evaluate no candidate.
  - MINES=0 therefore spends exactly one cycle in PLACE.
- WRITE:
  - Cell index starts at 0.
  - Each cycle: `wr_en`=1, `wr_addr`=index, `wr_data[4]`=bitmap[index], `wr_data[3:0]`=popcount of existing in-board neighbours (up to 8).
  - Neighbours off the edge count as 0; there is no wrap-around between row ends.
  - Mine cells also carry their true neighbour count.
  - After index N-1, go to DONE.
- DONE: `ultima_casilla`=1 for one cycle, then IDLE.
- `start` in PLACE, WRITE or DONE is ignored and not queued.
- Reset mid-operation:
  - Returns immediately to IDLE.
  - Clears the bitmap, counter and index; reloads LFSR_SEED.
  - Drops all outputs.
  - No partial-board recovery; the board memory contents are don't-care until the next complete WRITE pass.

## Timing
- Reset values: `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `ultima_casilla`=0, state IDLE, LFSR=LFSR_SEED.
- All outputs are registered or decoded from registered state only; there is no combinational path from `start`.
- Sequence, with `start` sampled high at edge k:
  - PLACE from k+1.
  - If PLACE lasts P cycles, WRITE occupies edges k+1+P .. k+P+N.
  - DONE, with the `ultima_casilla` pulse, at k+P+N+1.
  - IDLE at k+P+N+2; a new `start` is accepted from that cycle.
- P = 1 + number of cycles until the MINES-th accept. P is deterministic for a given seed and start cycle; there is no upper bound guarantee, but the LFSR period 65535 ensures progress.
- `busy` is high exactly during PLACE and WRITE and low in DONE.

## Test plan
- MINES=0, 8x8, start at cycle 10 after reset release -> 64 consecutive writes, addr 0..63, all data 5'b00000; `ultima_casilla` pulses exactly 66 cycles after start is sampled; `busy` high 65 cycles.
- Default parameters, fixed start cycle -> exactly 10 writes with bit4=1, all addresses distinct and < 64; every count matches a bench neighbour model; repeating the run from reset with the same start cycle gives an identical board.
- 4x4 with MINES=15 -> exactly one cell has bit4=0, and its count is 3 if a corner, 5 if an edge, 8 if interior; mine cells also match the model.
- Wrap check: mines forced via a bench seed sweep in column COLS-1 -> cells in column 0 of the next row do not count them.
- `start` pulsed during PLACE and during WRITE -> no restart, write sequence uninterrupted, single `ultima_casilla`.
- `rst` low during WRITE at addr 20 -> next cycle `wr_en`=0, `busy`=0, outputs 0; a fresh `start` produces a full 0..N-1 write pass with the seed-reset LFSR sequence.

Source files
------------

// File: rtl/mine_field_init.sv
// Minesweeper board initialisation.
// Places MINES mines with a free-running 16-bit Galois LFSR, then streams one
// cell word per cycle (mine flag + adjacent-mine count) in row-major order and
// pulses ultima_casilla once the last cell has been written.
// Ports:
//   clk            - clock, rising edge
//   rst            - asynchronous active-low reset
//   start          - single-cycle build request, honoured only when idle
//   wr_en          - board memory write strobe
//   wr_addr        - cell address (row*COLS+col)
//   wr_data        - [4] mine flag, [3:0] adjacent mine count
//   busy           - high while placing mines or writing the board
//   ultima_casilla - one-cycle pulse after the final cell write
module mine_field_init #(
  parameter int unsigned ROWS      = 8,
  parameter int unsigned COLS      = 8,
  parameter int unsigned MINES     = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           wr_en,
  output logic [$clog2(ROWS*COLS)-1:0]   wr_addr,
  output logic [4:0]                     wr_data,
  output logic                           busy,
  output logic                           ultima_casilla
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned AW   = $clog2(N);
  localparam int unsigned NP   = 2 ** AW;
  localparam int unsigned RW   = $clog2(ROWS);
  localparam int unsigned CLW  = $clog2(COLS);
  localparam int unsigned CNTW = (MINES > 0) ? $clog2(MINES + 1) : 1;
  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [AW:0] N_W       = (AW + 1)'(N);

  typedef enum logic [1:0] {IDLE, PLACE, WRITE, DONE} state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [N-1:0]    bitmap_q, bitmap_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CLW-1:0]  col_q, col_d;
  logic [NP-1:0]   bm_pad;
  logic [AW-1:0]   cand;
  logic            cand_ok;
  logic [3:0]      nbr_cnt;

  // Galois LFSR step; runs every cycle regardless of state
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
  end

  // Bitmap padded to a power of two so any candidate index is in range
  assign bm_pad  = NP'(bitmap_q);
  assign cand    = lfsr_q[AW-1:0];
  assign cand_ok = ({1'b0, cand} < N_W) && !bm_pad[cand];

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    row_d    = row_q;
    col_d    = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          bitmap_d = '0;
          cnt_d    = '0;
          state_d  = PLACE;
        end
      end
      PLACE: begin
        // Count check comes first: the cycle that sees MINES placed takes no candidate
        if (cnt_q == CNTW'(MINES)) begin
          state_d = WRITE;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
        end else if (cand_ok) begin
          bitmap_d = bitmap_q | (N'(1) << cand);
          cnt_d    = cnt_q + CNTW'(1);
        end
      end
      WRITE: begin
        if (idx_q == AW'(N - 1)) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + AW'(1);
          if (col_q == CLW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RW'(1);
          end else begin
            col_d = col_q + CLW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adjacent-mine count for the cell written next; edges clip, no row wrap
  always_comb begin
    int r;
    int c;
    nbr_cnt = '0;
    r = 0;
    c = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        r = int'(row_d) + dr;
        c = int'(col_d) + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < int'(ROWS) &&
            c >= 0 && c < int'(COLS)) begin
          nbr_cnt = nbr_cnt + 4'(bm_pad[AW'(r * int'(COLS) + c)]);
        end
      end
    end
  end

  // State, datapath and registered outputs (outputs track the next state)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      lfsr_q         <= LFSR_SEED;
      bitmap_q       <= '0;
      cnt_q          <= '0;
      idx_q          <= '0;
      row_q          <= '0;
      col_q          <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      ultima_casilla <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      bitmap_q       <= bitmap_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      row_q          <= row_d;
      col_q          <= col_d;
      wr_en          <= (state_d == WRITE);
      wr_addr        <= (state_d == WRITE) ? idx_d : '0;
      wr_data        <= (state_d == WRITE) ? {bm_pad[idx_d], nbr_cnt} : 5'd0;
      busy           <= (state_d == PLACE) || (state_d == WRITE);
      ultima_casilla <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mine_field_init.sv
// Self-checking bench for mine_field_init: three instances (8x8/10 mines,
// 4x4/15 mines, 8x8/0 mines) driven by directed runs; expected boards come
// from a bench LFSR/placement/neighbour model.
module tb_mine_field_init;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  logic start_a, start_b, start_c;
  logic wr_en_a, wr_en_b, wr_en_c;
  logic [5:0] wr_addr_a, wr_addr_c;
  logic [3:0] wr_addr_b;
  logic [4:0] wr_data_a, wr_data_b, wr_data_c;
  logic busy_a, busy_b, busy_c, ult_a, ult_b, ult_c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  mine_field_init #(.ROWS(8), .COLS(8), .MINES(10), .LFSR_SEED(SEED)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
    .wr_data(wr_data_a), .busy(busy_a), .ultima_casilla(ult_a));
  mine_field_init #(.ROWS(4), .COLS(4), .MINES(15), .LFSR_SEED(SEED)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .ultima_casilla(ult_b));
  mine_field_init #(.ROWS(8), .COLS(8), .MINES(0), .LFSR_SEED(SEED)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c),
    .wr_data(wr_data_c), .busy(busy_c), .ultima_casilla(ult_c));

  logic       m_en   [3];
  int         m_addr [3];
  logic [4:0] m_data [3];
  logic       m_busy [3];
  logic       m_ult  [3];
  assign m_en[0] = wr_en_a;  assign m_addr[0] = int'(wr_addr_a); assign m_data[0] = wr_data_a;
  assign m_en[1] = wr_en_b;  assign m_addr[1] = int'(wr_addr_b); assign m_data[1] = wr_data_b;
  assign m_en[2] = wr_en_c;  assign m_addr[2] = int'(wr_addr_c); assign m_data[2] = wr_data_c;
  assign m_busy[0] = busy_a; assign m_busy[1] = busy_b; assign m_busy[2] = busy_c;
  assign m_ult[0]  = ult_a;  assign m_ult[1]  = ult_b;  assign m_ult[2]  = ult_c;

  int         wcount [3];
  int         seq_err [3];
  int         busy_cnt [3];
  int         ult_cnt [3];
  int         ult_edge [3];
  int         first_edge [3];
  logic [4:0] board [3][256];
  logic [4:0] saved [256];

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Edge counter and reference LFSR
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk or negedge rst) begin
    if (!rst) lfsr_m <= SEED;
    else      lfsr_m <= lfsr_step(lfsr_m);
  end

  // Output monitor; an output seen at this negedge is sampled downstream at edge cyc+1
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (m_en[i]) begin
        if (wcount[i] == 0) first_edge[i] = cyc + 1;
        if (m_addr[i] != wcount[i]) seq_err[i]++;
        board[i][m_addr[i]] = m_data[i];
        wcount[i]++;
      end
      if (m_busy[i]) busy_cnt[i]++;
      if (m_ult[i]) begin
        ult_cnt[i]++;
        ult_edge[i] = cyc + 1;
      end
    end
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic set_start(input int i, input logic v);
    case (i)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic clear_mon(input int i);
    wcount[i] = 0; seq_err[i] = 0; busy_cnt[i] = 0;
    ult_cnt[i] = 0; ult_edge[i] = -1; first_edge[i] = -1;
    for (int a = 0; a < 256; a++) board[i][a] = 5'h1f;
  endtask

  function automatic int nbr_model(input logic [255:0] bm, input int rows, input int cols,
                                   input int r, input int c);
    int s = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < rows && c + dc >= 0 && c + dc < cols)
          s += int'(bm[(r + dr) * cols + c + dc]);
    return s;
  endfunction

  // Placement model: l0 is the LFSR value in the cycle start is sampled
  task automatic model_board(input logic [15:0] l0, input int rows, input int cols,
                             input int aw, input int mines,
                             output logic [255:0] bm, output int p);
    logic [15:0] l = l0;
    int n = rows * cols;
    int cnt = 0;
    int cand;
    bm = '0;
    p  = 0;
    while (p < 70000) begin
      l = lfsr_step(l);
      p++;
      if (cnt == mines) break;
      cand = int'(l) & ((1 << aw) - 1);
      if (cand < n && !bm[cand]) begin
        bm[cand] = 1'b1;
        cnt++;
      end
    end
  endtask

  task automatic verify(input int i, input int rows, input int cols, input int mines,
                        input logic [255:0] bm, input int p, input int k);
    int n = rows * cols;
    int nm = 0;
    check_val("wr_count", wcount[i], n);
    check_val("addr_seq_err", seq_err[i], 0);
    check_val("ult_pulses", ult_cnt[i], 1);
    check_val("ult_edge", ult_edge[i], k + p + n + 1);
    check_val("busy_cycles", busy_cnt[i], p + n);
    check_val("first_wr_edge", first_edge[i], k + p + 1);
    for (int a = 0; a < n; a++) nm += int'(board[i][a][4]);
    check_val("mine_count", nm, mines);
    for (int a = 0; a < n; a++) begin
      logic [4:0] exp_d;
      int r = a / cols;
      int c = a % cols;
      exp_d = {bm[a], 4'(nbr_model(bm, rows, cols, r, c))};
      if (c == 0 && r > 0 && bm[a - 1])
        check_val($sformatf("wrap_cell%0d", a), board[i][a], exp_d);
      else
        check_val($sformatf("cell%0d", a), board[i][a], exp_d);
    end
  endtask

  // One complete build on instance i; optional extra start pulses in PLACE and WRITE
  task automatic do_run(input int i, input int rows, input int cols, input int aw,
                        input int mines, input bit extra,
                        output logic [255:0] bm, output int p, output int k);
    logic [15:0] l0;
    clear_mon(i);
    l0 = lfsr_m;
    set_start(i, 1'b1);
    step();
    k = cyc;
    set_start(i, 1'b0);
    model_board(l0, rows, cols, aw, mines, bm, p);
    for (int t = 1; t < 5000 && ult_cnt[i] == 0; t++) begin
      set_start(i, extra && (t == 3 || t == p + 20));
      step();
    end
    set_start(i, 1'b0);
    if (ult_cnt[i] == 0) check_val("timeout", 0, 1);
    repeat (4) step();
    verify(i, rows, cols, mines, bm, p, k);
  endtask

  task automatic reset_and_wait();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    repeat (9) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] bm;
    int p, k, cnt0, e, exp_n, d_sel;
    logic hit;
    rst = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    for (int i = 0; i < 3; i++) clear_mon(i);
    repeat (3) step();
    check_val("rst_wr_en", wr_en_a, 0);
    check_val("rst_wr_addr", wr_addr_a, 0);
    check_val("rst_wr_data", wr_data_a, 0);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_ult", ult_a, 0);
    check_val("rst_busy_b", busy_b, 0);

    // MINES=0, start ten cycles after reset release
    rst = 1'b1;
    repeat (9) step();
    do_run(2, 8, 8, 6, 0, 1'b0, bm, p, k);
    check_val("m0_ult_after_start", ult_edge[2] - k, 66);
    check_val("m0_busy", busy_cnt[2], 65);
    check_val("m0_nonzero_data", (board[2][0] | board[2][37] | board[2][63]), 0);

    // Default board twice from reset with the same start cycle
    reset_and_wait();
    do_run(0, 8, 8, 6, 10, 1'b0, bm, p, k);
    for (int a = 0; a < 64; a++) saved[a] = board[0][a];
    reset_and_wait();
    do_run(0, 8, 8, 6, 10, 1'b0, bm, p, k);
    for (int a = 0; a < 64; a++) check_val($sformatf("repeat%0d", a), board[0][a], saved[a]);

    // 4x4 with 15 mines: single empty cell
    do_run(1, 4, 4, 4, 15, 1'b0, bm, p, k);
    cnt0 = 0; e = -1;
    for (int a = 0; a < 16; a++) if (!board[1][a][4]) begin cnt0++; e = a; end
    check_val("b_empty_cells", cnt0, 1);
    if (e >= 0) begin
      bit re = (e / 4 == 0) || (e / 4 == 3);
      bit ce = (e % 4 == 0) || (e % 4 == 3);
      exp_n = (re && ce) ? 3 : ((re || ce) ? 5 : 8);
      check_val("b_empty_nbr", board[1][e][3:0], exp_n);
    end

    // Start delay chosen so a mine sits in the last column above another row
    d_sel = 0;
    begin
      logic [15:0] ls = lfsr_m;
      bit found = 1'b0;
      for (int d = 0; d < 300 && !found; d++) begin
        logic [255:0] tb_bm;
        int tp;
        model_board(ls, 8, 8, 6, 10, tb_bm, tp);
        for (int r = 0; r < 7; r++) if (tb_bm[r * 8 + 7]) found = 1'b1;
        if (found) d_sel = d;
        ls = lfsr_step(ls);
      end
    end
    repeat (d_sel) step();
    do_run(0, 8, 8, 6, 10, 1'b0, bm, p, k);

    // Start pulses during PLACE and WRITE are ignored
    do_run(0, 8, 8, 6, 10, 1'b1, bm, p, k);

    // Reset in the middle of the write pass, then a clean rebuild
    clear_mon(0);
    set_start(0, 1'b1);
    step();
    set_start(0, 1'b0);
    hit = 1'b0;
    for (int t = 0; t < 5000 && !hit; t++) begin
      step();
      if (wr_en_a && wr_addr_a == 6'd20) hit = 1'b1;
    end
    check_val("abort_reached_addr20", hit, 1);
    rst = 1'b0;
    step();
    check_val("abort_wr_en", wr_en_a, 0);
    check_val("abort_busy", busy_a, 0);
    check_val("abort_wr_addr", wr_addr_a, 0);
    check_val("abort_wr_data", wr_data_a, 0);
    check_val("abort_ult", ult_a, 0);
    rst = 1'b1;
    repeat (2) step();
    do_run(0, 8, 8, 6, 10, 1'b0, bm, p, k);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
